// File: rtl/ip_tx_arbiter_pkg.sv
// Shared types for the IP transmit arbiter: FSM encoding and IPv4 header field widths.
package ip_tx_arbiter_pkg;

  localparam int DSCP_W   = 6;
  localparam int ECN_W    = 2;
  localparam int LENGTH_W = 16;
  localparam int TTL_W    = 8;
  localparam int PROTO_W  = 8;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 8;

  typedef enum logic {
    STATE_IDLE    = 1'b0,
    STATE_PAYLOAD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [DSCP_W-1:0]   dscp;
    logic [ECN_W-1:0]    ecn;
    logic [LENGTH_W-1:0] length;
    logic [TTL_W-1:0]    ttl;
    logic [PROTO_W-1:0]  protocol;
    logic [ADDR_W-1:0]   source_ip;
    logic [ADDR_W-1:0]   dest_ip;
  } ip_hdr_t;

endpackage

// File: rtl/ip_rr_select.sv
// Combinational winner picker: first requester at or after ptr (round robin)
// or lowest requesting index (fixed priority).
module ip_rr_select #(
  parameter int N_PORTS     = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int IDX_W       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int                base;
  int                pos;
  logic [IDX_W-1:0]  cand;

  // Scan the ports starting at the priority base, wrapping, and keep the first hit.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    pos          = 0;
    cand         = '0;
    base         = (ROUND_ROBIN != 0) ? int'(ptr) : 0;
    for (int i = 0; i < N_PORTS; i++) begin
      pos = base + i;
      if (pos >= N_PORTS) pos = pos - N_PORTS;
      cand = IDX_W'(pos);
      if (!grant_valid && req[cand]) begin
        grant_valid        = 1'b1;
        grant_idx          = cand;
        grant_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Packet-granular arbiter sharing the IPv4 block's IP transmit input between
// N_PORTS protocol engines. The winner's header is registered; its payload is
// forwarded combinationally until tlast, then the arbiter returns to idle.
module ip_tx_arbiter
  import ip_tx_arbiter_pkg::*;
#(
  parameter int N_PORTS     = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_PORTS-1:0]            s_ip_hdr_valid,
  output logic [N_PORTS-1:0]            s_ip_hdr_ready,
  input  logic [DSCP_W*N_PORTS-1:0]     s_ip_dscp,
  input  logic [ECN_W*N_PORTS-1:0]      s_ip_ecn,
  input  logic [LENGTH_W*N_PORTS-1:0]   s_ip_length,
  input  logic [TTL_W*N_PORTS-1:0]      s_ip_ttl,
  input  logic [PROTO_W*N_PORTS-1:0]    s_ip_protocol,
  input  logic [ADDR_W*N_PORTS-1:0]     s_ip_source_ip,
  input  logic [ADDR_W*N_PORTS-1:0]     s_ip_dest_ip,
  input  logic [DATA_W*N_PORTS-1:0]     s_ip_payload_axis_tdata,
  input  logic [N_PORTS-1:0]            s_ip_payload_axis_tvalid,
  input  logic [N_PORTS-1:0]            s_ip_payload_axis_tlast,
  input  logic [N_PORTS-1:0]            s_ip_payload_axis_tuser,
  output logic [N_PORTS-1:0]            s_ip_payload_axis_tready,
  output logic                          m_ip_hdr_valid,
  input  logic                          m_ip_hdr_ready,
  output logic [DSCP_W-1:0]             m_ip_dscp,
  output logic [ECN_W-1:0]              m_ip_ecn,
  output logic [LENGTH_W-1:0]           m_ip_length,
  output logic [TTL_W-1:0]              m_ip_ttl,
  output logic [PROTO_W-1:0]            m_ip_protocol,
  output logic [ADDR_W-1:0]             m_ip_source_ip,
  output logic [ADDR_W-1:0]             m_ip_dest_ip,
  output logic [DATA_W-1:0]             m_ip_payload_axis_tdata,
  output logic                          m_ip_payload_axis_tvalid,
  output logic                          m_ip_payload_axis_tlast,
  output logic                          m_ip_payload_axis_tuser,
  input  logic                          m_ip_payload_axis_tready,
  output logic [N_PORTS-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  arb_state_e         state_q, state_d;
  ip_hdr_t            hdr_q, sel_hdr;
  logic               hdr_valid_q;
  logic [N_PORTS-1:0] grant_q;
  logic [N_PORTS-1:0] hdr_ready_q;
  logic [IDX_W-1:0]   win_idx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   next_ptr;
  logic [N_PORTS-1:0] sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               arbitrate;
  logic               pkt_end;

  ip_rr_select #(
    .N_PORTS     (N_PORTS),
    .ROUND_ROBIN (ROUND_ROBIN),
    .IDX_W       (IDX_W)
  ) u_select (
    .req          (s_ip_hdr_valid),
    .ptr          (ptr_q),
    .grant_onehot (sel_onehot),
    .grant_idx    (sel_idx),
    .grant_valid  (sel_valid)
  );

  assign arbitrate = (state_q == STATE_IDLE) && sel_valid;
  assign pkt_end   = (state_q == STATE_PAYLOAD) && m_ip_payload_axis_tvalid &&
                     m_ip_payload_axis_tready && m_ip_payload_axis_tlast;
  assign next_ptr  = (win_idx_q == IDX_W'(N_PORTS - 1)) ? '0 : win_idx_q + IDX_W'(1);

  // Pull the selected requester's header fields out of the packed port buses.
  always_comb begin
    sel_hdr = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (sel_onehot[i]) begin
        sel_hdr.dscp      = s_ip_dscp[i*DSCP_W +: DSCP_W];
        sel_hdr.ecn       = s_ip_ecn[i*ECN_W +: ECN_W];
        sel_hdr.length    = s_ip_length[i*LENGTH_W +: LENGTH_W];
        sel_hdr.ttl       = s_ip_ttl[i*TTL_W +: TTL_W];
        sel_hdr.protocol  = s_ip_protocol[i*PROTO_W +: PROTO_W];
        sel_hdr.source_ip = s_ip_source_ip[i*ADDR_W +: ADDR_W];
        sel_hdr.dest_ip   = s_ip_dest_ip[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STATE_IDLE;
    else        state_q <= state_d;
  end

  // Next state: own a packet after a win, give it up on the tlast beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_IDLE:    if (sel_valid) state_d = STATE_PAYLOAD;
      STATE_PAYLOAD: if (pkt_end)   state_d = STATE_IDLE;
    endcase
  end

  // Header capture, grant ownership, hdr_ready pulse and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      grant_q     <= '0;
      hdr_ready_q <= '0;
      win_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      hdr_ready_q <= '0;
      if (arbitrate) begin
        hdr_q       <= sel_hdr;
        hdr_valid_q <= 1'b1;
        grant_q     <= sel_onehot;
        hdr_ready_q <= sel_onehot;
        win_idx_q   <= sel_idx;
      end else if (hdr_valid_q && m_ip_hdr_ready) begin
        hdr_valid_q <= 1'b0;
      end
      if (pkt_end) begin
        grant_q <= '0;
        if (ROUND_ROBIN != 0) ptr_q <= next_ptr;
      end
    end
  end

  // Payload path follows the owner; grant is zero when idle so everything idles too.
  always_comb begin
    m_ip_payload_axis_tdata  = '0;
    m_ip_payload_axis_tvalid = 1'b0;
    m_ip_payload_axis_tlast  = 1'b0;
    m_ip_payload_axis_tuser  = 1'b0;
    s_ip_payload_axis_tready = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_q[i]) begin
        m_ip_payload_axis_tdata     = s_ip_payload_axis_tdata[i*DATA_W +: DATA_W];
        m_ip_payload_axis_tvalid    = s_ip_payload_axis_tvalid[i];
        m_ip_payload_axis_tlast     = s_ip_payload_axis_tlast[i];
        m_ip_payload_axis_tuser     = s_ip_payload_axis_tuser[i];
        s_ip_payload_axis_tready[i] = m_ip_payload_axis_tready;
      end
    end
  end

  assign s_ip_hdr_ready = hdr_ready_q;
  assign m_ip_hdr_valid = hdr_valid_q;
  assign m_ip_dscp      = hdr_q.dscp;
  assign m_ip_ecn       = hdr_q.ecn;
  assign m_ip_length    = hdr_q.length;
  assign m_ip_ttl       = hdr_q.ttl;
  assign m_ip_protocol  = hdr_q.protocol;
  assign m_ip_source_ip = hdr_q.source_ip;
  assign m_ip_dest_ip   = hdr_q.dest_ip;
  assign grant          = grant_q;
  assign busy           = (state_q != STATE_IDLE);

endmodule

// File: doc/ip_tx_arbiter.md
Name: ip_tx_arbiter

Overview:
- Shares the single IP transmit input (s_ip_* header plus payload stream) of the IPv4 block between N_PORTS upstream protocol engines, e.g. UDP, ICMP and a raw-frame generator.
- Arbitrates at packet granularity and registers the winner's header.
- Forwards the winner's payload untouched until tlast, then re-arbitrates.
- Sits directly in front of the IPv4 block's IP input.

Parameters:
- N_PORTS, 2, number of requesters (2..8).
- ROUND_ROBIN, 1, 1 = rotate priority after each packet; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_ip_hdr_valid  in  N_PORTS  per-port header valid
- s_ip_hdr_ready  out  N_PORTS  per-port header accept (one-cycle pulse)
- s_ip_dscp  in  6*N_PORTS  packed per port; port i at [6i+5:6i]; same packing for all s_ fields below
- s_ip_ecn  in  2*N_PORTS  per-port ECN
- s_ip_length  in  16*N_PORTS  per-port total length
- s_ip_ttl  in  8*N_PORTS  per-port TTL
- s_ip_protocol  in  8*N_PORTS  per-port protocol
- s_ip_source_ip  in  32*N_PORTS  per-port source address
- s_ip_dest_ip  in  32*N_PORTS  per-port destination address
- s_ip_payload_axis_tdata  in  8*N_PORTS  per-port payload byte
- s_ip_payload_axis_tvalid / tlast / tuser  in  N_PORTS each  per-port stream sideband
- s_ip_payload_axis_tready  out  N_PORTS  per-port payload ready
- m_ip_hdr_valid  out  1  output header valid
- m_ip_hdr_ready  in  1  output header ready
- m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl, m_ip_protocol, m_ip_source_ip, m_ip_dest_ip  out  6/2/16/8/8/32/32  registered header of the granted port
- m_ip_payload_axis_tdata  out  8  payload byte
- m_ip_payload_axis_tvalid / tlast / tuser  out  1 each  payload sideband
- m_ip_payload_axis_tready  in  1  payload ready
- grant  out  N_PORTS  one-hot current owner; 0 when idle
- busy  out  1  high while a packet is owned

Behaviour:
- Reset: all outputs 0, state IDLE, grant 0, round-robin pointer 0, header registers 0.
- STATE_IDLE:
  - When any s_ip_hdr_valid is high, the arbiter picks a winner W.
  - In the same edge it latches W's header fields into the m_ip_* registers and sets grant = onehot(W).
  - It pulses s_ip_hdr_ready[W] = 1 for exactly the next cycle and sets m_ip_hdr_valid = 1.
  - Next state is STATE_PAYLOAD.
  - Latency from s_ip_hdr_valid to s_ip_hdr_ready/m_ip_hdr_valid is 1 cycle.
- Winner selection:
  - ROUND_ROBIN=1: the first requesting index at or after ptr, wrapping modulo N_PORTS.
  - ROUND_ROBIN=0: the lowest requesting index.
- STATE_PAYLOAD:
  - m_ip_hdr_valid clears on the cycle m_ip_hdr_ready is sampled high, and never re-asserts within the packet.
  - Payload path is combinational: m_tdata/tvalid/tlast/tuser = port W's signals, and s_tready[W] = m_ip_payload_axis_tready.
  - All other s_tready and s_hdr_ready stay 0.
  - Payload may flow while the header is still pending; downstream governs via tready.
- End of packet:
  - Triggered by tvalid & tready & tlast on port W.
  - Next state IDLE; grant and busy clear on the next cycle.
  - With ROUND_ROBIN=1, ptr = (W+1) mod N_PORTS.
  - Re-arbitration can occur the cycle after return to IDLE, so the minimum gap between packets is 1 idle cycle.
- Simultaneous requests: exactly one winner; losers hold valid and are served in later packets (no starvation under ROUND_ROBIN=1).
- New s_ip_hdr_valid on a non-owner during PAYLOAD is ignored until IDLE.
- A requester dropping hdr_valid before its ready is a protocol violation; no recovery logic is required.
- tuser is forwarded as-is and has no effect on sequencing.
- Reset mid-packet returns to the reset state immediately. Any partial packet downstream is truncated, and tready drops to 0 asynchronously with reset.
- busy = (state != IDLE).

Decomposition:
- Shared package: state encoding (STATE_IDLE=1'b0, STATE_PAYLOAD=1'b1) and the IP header field widths (DSCP 6, ECN 2, LENGTH 16, TTL 8, PROTO 8, ADDR 32).
- One sub-module: ip_rr_select. It is combinational: request vector plus ptr in, one-hot grant plus index out, with fixed-priority mode via the ROUND_ROBIN parameter.
- The header register, state machine and payload mux live in ip_tx_arbiter.

Test Plan:
- Single port, N_PORTS=2:
  - Stimulus: port1 sends dest 10.0.0.5, length 28, protocol 17, payload 8 bytes.
  - Required: s_ip_hdr_ready[1] high 1 cycle after valid; m_ip_dest_ip=32'h0A000005; 8 bytes out in order; grant=2'b10 during the packet; busy clears 1 cycle after tlast.
- Simultaneous requests, ROUND_ROBIN=1:
  - Stimulus: ports 0 and 1 both valid in the same cycle after reset.
  - Required: order is port 0 then port 1; port 1's header is accepted the 2nd cycle after port 0's tlast beat.
- Fixed priority, ROUND_ROBIN=0:
  - Stimulus: port 0 requests continuously; port 1 waits.
  - Required: port 0 wins every arbitration; port 1's s_ip_hdr_ready never asserts.
- Backpressure:
  - Stimulus: m_ip_hdr_ready held 0 for 5 cycles; m_payload tready toggled 1010.
  - Required: m_ip_hdr_valid stays high and fields stable for 5 cycles; the loser's tready stays 0; no byte is lost or duplicated.
- Reset mid-packet:
  - Stimulus: rst_n low at byte 3 of 10.
  - Required: all outputs 0 that cycle; after release, a new request from port 1 is granted since ptr was reset to 0 and port 0 is idle.
- Wrap-around, N_PORTS=4:
  - Stimulus: all 4 ports request continuously with single-byte packets.
  - Required: grant sequence 0,1,2,3,0.
